// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, parity codes and baud divisor helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD = 1;
  localparam int PAR_EVEN = 2;
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO; push when full and pop when empty are dropped
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk50,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] level_q;
  logic do_push, do_pop;
  assign full = level_q == (AW+1)'(DEPTH);
  assign empty = level_q == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem_q[rd_q];
  assign level = level_q;
  always_ff @(posedge clk50) if (do_push) mem_q[wr_q] <= din;
  always_ff @(posedge clk50) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
    end else begin
      wr_q <= do_push ? wr_q + AW'(1) : wr_q;
      rd_q <= do_pop ? rd_q + AW'(1) : rd_q;
      level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter, LSB first, optional parity and 2 stop bits
module uart_tx_fifo import uart_pkg::*; #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD = 115200,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk50,
  input  logic                          reset,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int DIV = baud_div(CLK_HZ, BAUD);
  localparam int CW = $clog2(STOP_BITS * DIV + 1);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  tx_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d, head;
  logic par_q, par_d, tx_q, tx_d, busy_q, busy_d;
  logic push, pop, full, empty, bit_end, load;
  logic [LW-1:0] lvl_nxt;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk50(clk50), .reset(reset), .push(push), .pop(pop), .din(tx_data),
    .dout(head), .level(fifo_level), .full(full), .empty(empty)
  );
  assign tx_ready = !reset && !full;
  assign push = tx_valid && tx_ready;
  // the stop phase is timed as one long bit so two stop bits need no extra state
  assign bit_end = cnt_q == (state_q == STOP ? CW'(STOP_BITS * DIV - 1) : CW'(DIV - 1));
  assign load = !empty && (state_q == IDLE || (state_q == STOP && bit_end));
  assign pop = load;
  assign lvl_nxt = fifo_level + LW'(push) - LW'(pop);
  always_comb begin
    state_d = state_q;
    cnt_d = (state_q == IDLE || bit_end) ? '0 : cnt_q + CW'(1);
    bit_d = bit_q;
    sh_d = sh_q;
    par_d = par_q;
    tx_d = tx_q;
    case (state_q)
      IDLE: tx_d = 1'b1;
      START: if (bit_end) begin
        state_d = DATA;
        tx_d = sh_q[0];
      end
      DATA: if (bit_end) begin
        if (bit_q == 3'd7) begin
          state_d = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
          tx_d = (PARITY != PAR_NONE) ? par_q : 1'b1;
        end else begin
          bit_d = bit_q + 3'd1;
          sh_d = sh_q >> 1;
          tx_d = sh_q[1];
        end
      end
      uart_pkg::PARITY: if (bit_end) begin
        state_d = STOP;
        tx_d = 1'b1;
      end
      STOP: if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d = START;
      tx_d = 1'b0;
      sh_d = head;
      bit_d = '0;
      par_d = (PARITY == PAR_ODD) ? ~^head : ^head;
    end
    busy_d = (state_d != IDLE) || (lvl_nxt != '0);
  end
  always_ff @(posedge clk50) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      par_q <= 1'b0;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      par_q <= par_d;
      tx_q <= tx_d;
      busy_q <= busy_d;
    end
  end
  assign uart_tx = tx_q;
  assign busy = busy_q;
endmodule
